// File: rtl/ce_serializer.sv
// ce_serializer
// Parallel-to-serial source stage for the enabled D flip-flop stage.
// A word is accepted on Load while Ready, then shifted out MSB-first on Din,
// one bit every DIV clocks, with a one-cycle Ce strobe in the last cycle of
// each bit period. A one-cycle Done pulse follows the last strobe, then the
// block returns to Ready. All outputs are decoded from registers only.

module ce_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV   = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Load,
   input  logic [WIDTH-1:0] Pdata,
   output logic             Ready,
   output logic             Ce,
   output logic             Din,
   output logic             Done
);

   // pcnt needs at least one bit even when DIV=1
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(WIDTH);

   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, stateNext;
   logic [WIDTH-1:0] shreg, shregNext;
   logic [PW-1:0]    pcnt, pcntNext;
   logic [BW-1:0]    bcnt, bcntNext;

   logic pcntEnd;
   logic bcntEnd;

   assign pcntEnd = (pcnt == PMAX);
   assign bcntEnd = (bcnt == BMAX);

   // State register; reset discards any word in flight
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         shreg <= '0;
         pcnt  <= '0;
         bcnt  <= '0;
      end else begin
         state <= stateNext;
         shreg <= shregNext;
         pcnt  <= pcntNext;
         bcnt  <= bcntNext;
      end
   end

   // Next-state logic: load in IDLE, count/shift in SHIFT, single-cycle DONE
   always_comb begin
      stateNext = state;
      shregNext = shreg;
      pcntNext  = pcnt;
      bcntNext  = bcnt;
      unique case (state)
         IDLE: begin
            if (Load) begin
               shregNext = Pdata;
               pcntNext  = '0;
               bcntNext  = '0;
               stateNext = SHIFT;
            end
         end
         SHIFT: begin
            if (!pcntEnd) begin
               pcntNext = pcnt + 1'b1;
            end else if (!bcntEnd) begin
               pcntNext  = '0;
               bcntNext  = bcnt + 1'b1;
               shregNext = {shreg[WIDTH-2:0], 1'b0};
            end else begin
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Output decode, registers only
   always_comb begin
      Ready = (state == IDLE);
      Done  = (state == DONE);
      Din   = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
      Ce    = (state == SHIFT) && pcntEnd;
   end

endmodule

// File: tb/tb_ce_serializer.sv
// tb_ce_serializer
// Two instances: WIDTH=8/DIV=2 (A) and WIDTH=8/DIV=1 (B). Stimulus pushes the
// expected bit stream into a per-instance queue; a monitor per instance pops
// one bit per Ce strobe and compares it with Din, and also checks a
// downstream flip-flop model captures the same bit.

module tb_ce_serializer;

   logic clk = 1'b0;
   logic rstN = 1'b1;

   logic       loadA = 1'b0, loadB = 1'b0;
   logic [7:0] pdataA = '0, pdataB = '0;
   logic       readyA, ceA, dinA, doneA;
   logic       readyB, ceB, dinB, doneB;

   int checks = 0;
   int failures = 0;

   logic expBitsA[$];
   logic expBitsB[$];
   int   ceCountA = 0, ceCountB = 0;
   logic qoutA, qoutB;
   logic prevCeA = 1'b0, prevCeB = 1'b0;
   logic prevBitA = 1'b0, prevBitB = 1'b0;
   logic popA, popB;

   always #5 clk = ~clk;

   ce_serializer #(.WIDTH(8), .DIV(2)) dutA (
      .CLK   (clk),
      .RST   (rstN),
      .Load  (loadA),
      .Pdata (pdataA),
      .Ready (readyA),
      .Ce    (ceA),
      .Din   (dinA),
      .Done  (doneA)
   );

   ce_serializer #(.WIDTH(8), .DIV(1)) dutB (
      .CLK   (clk),
      .RST   (rstN),
      .Load  (loadB),
      .Pdata (pdataB),
      .Ready (readyB),
      .Ce    (ceB),
      .Din   (dinB),
      .Done  (doneB)
   );

   // Downstream enabled flip-flops fed by each serializer
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         qoutA <= 1'b0;
         qoutB <= 1'b0;
      end else begin
         if (ceA) qoutA <= dinA;
         if (ceB) qoutB <= dinB;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Scoreboard monitor for instance A
   always @(negedge clk) begin
      if (rstN) begin
         if (prevCeA) checkOutput("A_qout", qoutA, prevBitA);
         if (ceA === 1'b1) begin
            ceCountA++;
            if (expBitsA.size() == 0) begin
               checkOutput("A_unexpectedCe", 1, 0);
            end else begin
               popA = expBitsA.pop_front();
               checkOutput("A_sbDin", dinA, popA);
            end
         end
         if (doneA === 1'b1) checkOutput("A_doneLeftover", expBitsA.size(), 0);
         prevCeA = ceA;
         prevBitA = dinA;
      end else begin
         prevCeA = 1'b0;
      end
   end

   // Scoreboard monitor for instance B
   always @(negedge clk) begin
      if (rstN) begin
         if (prevCeB) checkOutput("B_qout", qoutB, prevBitB);
         if (ceB === 1'b1) begin
            ceCountB++;
            if (expBitsB.size() == 0) begin
               checkOutput("B_unexpectedCe", 1, 0);
            end else begin
               popB = expBitsB.pop_front();
               checkOutput("B_sbDin", dinB, popB);
            end
         end
         if (doneB === 1'b1) checkOutput("B_doneLeftover", expBitsB.size(), 0);
         prevCeB = ceB;
         prevBitB = dinB;
      end else begin
         prevCeB = 1'b0;
      end
   end

   // Load one word into instance sel (0=A, 1=B); called at a negedge while Ready.
   // busyAt>0 pulses a rejected Load of 8'hFF in that cycle of the word.
   task automatic applyStimulus(input int sel, input logic [7:0] data, input int busyAt);
      int   div;
      int   doneAt;
      int   readyAt;
      int   idx;
      logic ce, din, done, ready;
      logic expCe, expDin;
      div = (sel == 0) ? 2 : 1;
      doneAt = 0;
      readyAt = 0;
      for (int i = 7; i >= 0; i--) begin
         if (sel == 0) expBitsA.push_back(data[i]);
         else          expBitsB.push_back(data[i]);
      end
      if (sel == 0) begin ceCountA = 0; loadA = 1'b1; pdataA = data; end
      else          begin ceCountB = 0; loadB = 1'b1; pdataB = data; end
      @(posedge clk);
      #1;
      loadA = 1'b0;
      loadB = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (sel == 0) begin ce = ceA; din = dinA; done = doneA; ready = readyA; end
         else          begin ce = ceB; din = dinB; done = doneB; ready = readyB; end
         expCe = (c <= 8 * div) && (c % div == 0);
         if (c <= 8 * div) begin
            idx = 7 - (c - 1) / div;
            expDin = data[idx];
         end else begin
            expDin = 1'b0;
         end
         checkOutput("cycleCe", ce, expCe);
         checkOutput("cycleDin", din, expDin);
         checkOutput("cycleReady", ready, (c >= 8 * div + 2));
         if (done === 1'b1 && doneAt == 0) doneAt = c;
         if (ready === 1'b1 && readyAt == 0) readyAt = c;
         if (busyAt != 0 && c == busyAt) begin
            if (sel == 0) begin loadA = 1'b1; pdataA = 8'hFF; end
            else          begin loadB = 1'b1; pdataB = 8'hFF; end
         end
         if (busyAt != 0 && c == busyAt + 1) begin
            loadA = 1'b0;
            loadB = 1'b0;
         end
         if (readyAt != 0) break;
      end
      checkOutput("doneCycle", doneAt, 8 * div + 1);
      checkOutput("readyCycle", readyAt, 8 * div + 2);
      checkOutput("ceCount", (sel == 0) ? ceCountA : ceCountB, 8);
   endtask

   // Watchdog so the bench always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence
   initial begin
      #2 rstN = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         loadA = ~loadA;
         loadB = ~loadB;
         pdataA = 8'hFF;
         pdataB = 8'hFF;
         #1;
         checkOutput("rstReadyA", readyA, 1);
         checkOutput("rstCeA", ceA, 0);
         checkOutput("rstDinA", dinA, 0);
         checkOutput("rstDoneA", doneA, 0);
         checkOutput("rstReadyB", readyB, 1);
         checkOutput("rstCeB", ceB, 0);
      end
      @(negedge clk);
      loadA = 1'b0;
      loadB = 1'b0;
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("postRstReadyA", readyA, 1);
      checkOutput("postRstReadyB", readyB, 1);

      $display("[TB] basic word A5 with busy load of FF in cycle 5");
      applyStimulus(0, 8'hA5, 5);
      $display("[TB] back-to-back word 3C");
      applyStimulus(0, 8'h3C, 0);

      $display("[TB] reset mid-word F0");
      @(negedge clk);
      for (int i = 7; i >= 0; i--) expBitsA.push_back(pdataA[0] ^ pdataA[0] ^ (i >= 4));
      ceCountA = 0;
      loadA = 1'b1;
      pdataA = 8'hF0;
      @(posedge clk);
      #1 loadA = 1'b0;
      for (int c = 0; c < 20 && ceCountA < 3; c++) @(negedge clk);
      checkOutput("ceBeforeReset", ceCountA, 3);
      @(posedge clk);
      #2 rstN = 1'b0;
      #1;
      checkOutput("midRstCe", ceA, 0);
      checkOutput("midRstDin", dinA, 0);
      checkOutput("midRstReady", readyA, 1);
      checkOutput("midRstDone", doneA, 0);
      expBitsA.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("inRstDone", doneA, 0);
         checkOutput("inRstReady", readyA, 1);
      end
      rstN = 1'b1;
      applyStimulus(0, 8'h81, 0);

      $display("[TB] DIV=1 instance word 96");
      @(negedge clk);
      applyStimulus(1, 8'h96, 0);

      repeat (3) @(negedge clk);
      checkOutput("leftoverA", expBitsA.size(), 0);
      checkOutput("leftoverB", expBitsB.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
